// File: rtl/mem_ctrl_pkg.sv
`timescale 1ns/1ps
// Shared encodings for the memory-access controller: FSM states, operation
// codes, default timeout limit and the op decoder used at capture time.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2
  } op_t;

  localparam int TIMEOUT_CYCLES_DEF = 15;

  // is_str only matters for data accesses; fetches never store.
  function automatic op_t decode_op(input logic sel_add_bus, input logic is_str);
    op_t op;
    if (!sel_add_bus) begin
      op = OP_FETCH;
    end else if (is_str) begin
      op = OP_STORE;
    end else begin
      op = OP_LOAD;
    end
    return op;
  endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
`timescale 1ns/1ps
// Wait-cycle counter for the ACCESS state. expired flags the cycle in which
// the next increment would make the count equal to limit.
module mem_timeout_ctr #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic             expired
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [CNT_W:0]   count_inc;

  assign count_inc = {1'b0, count_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_inc[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && !clear && (count_inc == {1'b0, limit});

endmodule

// File: rtl/memory_access_ctrl.sv
`timescale 1ns/1ps
// Single-transaction memory access controller (fetch / load / store) with
// registered Moore outputs. Defining MEM_TIMEOUT_EN adds the ACCESS timeout and ERR path.
module memory_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              sel_add_bus,
  input  logic              is_str,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        dbg_state
);

  // Handshake: mem_rd_en / mem_wr_en act as a valid that is held steady with
  // mem_addr / mem_wdata until mem_ready is sampled high on a rising edge;
  // the transfer completes on exactly that edge and the enable drops after it.

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("memory_access_ctrl: TIMEOUT_CYCLES must be in 1..255");
  end

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  logic tmo_clear;
  logic tmo_en;
  logic tmo_expired;
  logic err_q, err_d;

  mem_timeout_ctr #(
    .CNT_W (8)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_en),
    .limit   (TMO_LIMIT),
    .expired (tmo_expired)
  );
`endif

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    data_d  = data_q;
`ifdef MEM_TIMEOUT_EN
    tmo_clear = 1'b0;
    tmo_en    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d   = decode_op(sel_add_bus, is_str);
          addr_d = addr_in;
          if (op_d == OP_STORE) begin
            wdata_d = wdata_in;
          end
`ifdef MEM_TIMEOUT_EN
          tmo_clear = 1'b1;
`endif
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // A ready on the limit cycle completes normally rather than timing out.
        if (mem_ready) begin
          if (op_q != OP_STORE) begin
            data_d = mem_rdata;
          end
          state_d = ST_DONE;
        end else begin
`ifdef MEM_TIMEOUT_EN
          tmo_en = 1'b1;
          if (tmo_expired) begin
            state_d = ST_ERR;
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d != ST_IDLE);
    rd_en_d = (state_d == ST_ACCESS) && (op_d != OP_STORE);
    wr_en_d = (state_d == ST_ACCESS) && (op_d == OP_STORE);
    done_d  = (state_d == ST_DONE);
`ifdef MEM_TIMEOUT_EN
    err_d   = (state_d == ST_ERR);
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_FETCH;
      addr_q  <= '0;
      wdata_q <= '0;
      data_q  <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      data_q  <= data_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_rd_en = rd_en_q;
  assign mem_wr_en = wr_en_q;
  assign data_out  = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_memory_access_ctrl.sv
`timescale 1ns/1ps
// Directed bench for memory_access_ctrl: expected data_out values are queued
// when a transaction is issued and popped on its done pulse.
module tb_memory_access_ctrl;

  localparam int TMO = 15;

  logic        clk;
  logic        reset;
  logic        start;
  logic        sel_add_bus;
  logic        is_str;
  logic [15:0] addr_in;
  logic [31:0] wdata_in;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] data_out;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_data  = '0;
  logic [31:0] model_wdata = '0;
  logic [15:0] model_addr  = '0;

  memory_access_ctrl #(
    .ADDR_W         (16),
    .DATA_W         (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .sel_add_bus (sel_add_bus),
    .is_str      (is_str),
    .addr_in     (addr_in),
    .wdata_in    (wdata_in),
    .mem_addr    (mem_addr),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .data_out    (data_out),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit expired, observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver: one full transaction with `waits` not-ready cycles before ready
  task automatic do_txn(input logic sel, input logic st, input logic [15:0] addr,
                        input logic [31:0] wd, input int waits, input logic [31:0] rd,
                        input logic poke_busy);
    logic is_store;
    is_store   = sel && st;
    model_addr = addr;
    if (is_store) model_wdata = wd;
    else          model_data  = rd;
    exp_q.push_back(model_data);

    start       = 1'b1;
    sel_add_bus = sel;
    is_str      = st;
    addr_in     = addr;
    wdata_in    = wd;
    mem_ready   = 1'b0;
    tick();
    start    = 1'b0;
    addr_in  = 16'h0000;
    wdata_in = $urandom;
    for (int i = 0; i <= waits; i++) begin
      chk("acc_busy",  32'(busy), 32'd1);
      chk("acc_rd_en", 32'(mem_rd_en), 32'(!is_store));
      chk("acc_wr_en", 32'(mem_wr_en), 32'(is_store));
      chk("acc_addr",  32'(mem_addr), 32'(model_addr));
      chk("acc_done",  32'(done), 32'd0);
      if (poke_busy && i == 0) begin
        start       = 1'b1;
        sel_add_bus = 1'b1;
        is_str      = 1'b1;
        addr_in     = 16'h00FF;
        wdata_in    = 32'h5555_AAAA;
      end else begin
        start = 1'b0;
      end
      mem_ready = (i == waits);
      mem_rdata = (i == waits) ? rd : 32'($urandom);
      tick();
    end
    start     = 1'b0;
    mem_ready = 1'b0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_err",   32'(err), 32'd0);
    chk("done_rd_en", 32'(mem_rd_en), 32'd0);
    chk("done_wr_en", 32'(mem_wr_en), 32'd0);
    chk("done_addr",  32'(mem_addr), 32'(model_addr));
    chk("done_wdata", mem_wdata, model_wdata);
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      chk("data_out", data_out, exp_q.pop_front());
    end
    tick();
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_done", 32'(done), 32'd0);
  endtask

  initial begin
    reset       = 1'b1;
    start       = 1'b0;
    sel_add_bus = 1'b0;
    is_str      = 1'b0;
    addr_in     = '0;
    wdata_in    = '0;
    mem_rdata   = '0;
    mem_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_data",  data_out, 32'd0);
    chk("rst_rd_en", 32'(mem_rd_en), 32'd0);
    chk("rst_wr_en", 32'(mem_wr_en), 32'd0);
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_err",   32'(err), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    tick();

    // mem_ready toggling while idle must do nothing
    for (int i = 0; i < 6; i++) begin
      mem_ready = i[0];
      mem_rdata = $urandom;
      tick();
      chk("idle_done",  32'(done), 32'd0);
      chk("idle_busy",  32'(busy), 32'd0);
      chk("idle_data",  data_out, 32'd0);
      chk("idle_rd_en", 32'(mem_rd_en), 32'd0);
    end
    mem_ready = 1'b0;

    // fetch, immediate ready; is_str=1 must be ignored when sel_add_bus=0
    do_txn(1'b0, 1'b1, 16'h0012, 32'h1111_2222, 0, 32'hA5A5_0001, 1'b0);
    // store with 3 wait cycles; data_out must keep the fetched word
    do_txn(1'b1, 1'b1, 16'h0100, 32'hDEAD_BEEF, 3, 32'($urandom), 1'b0);
    // load with a start pulse (addr 00FF) while busy, which must be ignored
    do_txn(1'b1, 1'b0, 16'h0234, 32'($urandom), 2, 32'h0BAD_F00D, 1'b1);
    // ready on the last allowed wait cycle completes instead of timing out
    do_txn(1'b1, 1'b0, 16'h0456, 32'($urandom), TMO - 1, 32'h1234_5678, 1'b0);
    for (int k = 0; k < 4; k++) begin
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
             32'($urandom), $urandom_range(0, 5), 32'($urandom), 1'b0);
    end

    // load with mem_ready held low
    start       = 1'b1;
    sel_add_bus = 1'b1;
    is_str      = 1'b0;
    addr_in     = 16'h0300;
    mem_ready   = 1'b0;
    tick();
    start = 1'b0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < TMO; i++) begin
      chk("tmo_busy",  32'(busy), 32'd1);
      chk("tmo_rd_en", 32'(mem_rd_en), 32'd1);
      chk("tmo_err",   32'(err), 32'd0);
      tick();
    end
    chk("tmo_err_pulse", 32'(err), 32'd1);
    chk("tmo_err_rd_en", 32'(mem_rd_en), 32'd0);
    chk("tmo_err_done",  32'(done), 32'd0);
    chk("tmo_err_data",  data_out, model_data);
    tick();
    chk("tmo_err_clear", 32'(err), 32'd0);
    chk("tmo_idle_busy", 32'(busy), 32'd0);
`else
    for (int i = 0; i < 3 * TMO; i++) begin
      chk("wait_busy",  32'(busy), 32'd1);
      chk("wait_rd_en", 32'(mem_rd_en), 32'd1);
      chk("wait_err",   32'(err), 32'd0);
      tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_data  = '0;
    model_wdata = '0;
    tick();
    chk("wait_rst_busy", 32'(busy), 32'd0);
`endif

    // reset asserted mid-ACCESS drops the enable without a clock edge
    start       = 1'b1;
    sel_add_bus = 1'b1;
    is_str      = 1'b0;
    addr_in     = 16'h0400;
    tick();
    start = 1'b0;
    chk("mid_rd_en", 32'(mem_rd_en), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rd_en", 32'(mem_rd_en), 32'd0);
    chk("async_busy",  32'(busy), 32'd0);
    chk("async_done",  32'(done), 32'd0);
    chk("async_err",   32'(err), 32'd0);
    model_data  = '0;
    model_wdata = '0;
    tick();
    reset = 1'b0;
    tick();
    chk("after_rst_done", 32'(done), 32'd0);
    chk("after_rst_err",  32'(err), 32'd0);
    chk("after_rst_data", data_out, 32'd0);
    do_txn(1'b0, 1'b0, 16'h0012, 32'h0, 1, 32'hCAFE_0042, 1'b0);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memory_access_ctrl.md
# memory_access_ctrl

Sequential memory-access controller sitting directly downstream of the address-bus multiplexer. It captures the selected 16-bit address (PC fetch, or register-bank address for LDR/STR) and runs one read or write transaction against the memory port with a ready handshake. It returns fetched or loaded data to the datapath and reports completion or timeout. One transaction is in flight at a time.

## Interface
- ADDR_W, 16, address width (matches multiplexer output)
- DATA_W, 32, data word width
- TIMEOUT_CYCLES, 15, max ACCESS cycles waiting for mem_ready (range 1..255)
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  transaction request strobe, sampled in IDLE only
- sel_add_bus  input  1  0 = instruction fetch, 1 = data access (LDR or STR)
- is_str  input  1  1 = store; honoured only when sel_add_bus=1
- addr_in  input  ADDR_W  address from multiplexer
- wdata_in  input  DATA_W  store data from register bank
- mem_addr  output  ADDR_W  registered memory address
- mem_rd_en  output  1  read enable
- mem_wr_en  output  1  write enable
- mem_wdata  output  DATA_W  registered store data
- mem_rdata  input  DATA_W  read data, valid when mem_ready=1
- mem_ready  input  1  memory completes access this cycle
- data_out  output  DATA_W  last fetched/loaded word
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle timeout pulse

## Operation
- States: IDLE, ACCESS, DONE, ERR. Moore outputs, all registered.
- Op decode at capture: sel_add_bus=0 -> FETCH (is_str ignored); sel_add_bus=1,is_str=0 -> LOAD; sel_add_bus=1,is_str=1 -> STORE.
- IDLE: on start=1 latch addr_in into mem_addr, wdata_in into mem_wdata (STORE only; else unchanged), latch op; go ACCESS. start=0: stay.
- ACCESS: mem_rd_en=1 for FETCH/LOAD, mem_wr_en=1 for STORE; never both. Held until mem_ready sampled high. On mem_ready=1: reads load mem_rdata into data_out; go DONE.
- DONE: done=1, enables low, go IDLE.
- ERR: err=1, enables low, data_out unchanged, go IDLE.
- STORE never modifies data_out.
- start while busy=1 is ignored (no queueing); upstream must hold/reissue.
- mem_ready in IDLE, DONE, ERR ignored.
- Reset values: mem_addr=0, mem_wdata=0, data_out=0, mem_rd_en=0, mem_wr_en=0, busy=0, done=0, err=0, state IDLE, timeout count 0.
- Reset asserted mid-ACCESS: enables drop immediately (asynchronous), transaction abandoned, no done/err.

## Timing
- start sampled at edge N -> busy and enable high from edge N (registered outputs visible in cycle N+1).
- mem_ready high in first ACCESS cycle -> done high in cycle N+2; minimum start-to-done 2 cycles, next start accepted in cycle N+3.
- Each extra wait cycle adds one cycle of latency.
- Timeout counter clears on IDLE->ACCESS, increments each ACCESS cycle with mem_ready=0; when count reaches TIMEOUT_CYCLES go ERR. mem_ready=1 in the same cycle the limit is reached wins (DONE, not ERR).

## Configuration
- MEM_TIMEOUT_EN defined: timeout counter and ERR state compiled in as above.
- MEM_TIMEOUT_EN undefined: no counter, ACCESS waits indefinitely for mem_ready, err tied 0, TIMEOUT_CYCLES unused.

## Structure
- Shared package mem_ctrl_pkg: state encoding (IDLE/ACCESS/DONE/ERR), op encoding (FETCH/LOAD/STORE), default TIMEOUT_CYCLES constant.
- One sub-module: mem_timeout_ctr (clear, enable, limit, expired), instantiated only under MEM_TIMEOUT_EN.

## Test plan
- Reset then idle: all outputs 0, busy=0; toggling mem_ready alone -> no done, data_out=0.
- FETCH: sel_add_bus=0, addr_in=16'h0012, mem_ready=1 immediately with mem_rdata=32'hA5A5_0001 -> mem_rd_en one cycle, done in cycle N+2, data_out=32'hA5A5_0001.
- STORE with 3 wait cycles: addr 16'h0100, wdata 32'hDEAD_BEEF -> mem_wr_en held 4 cycles, mem_wdata=32'hDEAD_BEEF, done after ready, data_out unchanged.
- Timeout: LOAD, mem_ready held 0 -> after 15 ACCESS cycles err pulses once, enables drop, done stays 0; with macro undefined, busy stays high indefinitely.
- start reasserted during busy with addr 16'h00FF -> ignored; mem_addr keeps original address.
- Reset asserted during ACCESS -> mem_rd_en falls immediately, no done/err, next start proceeds normally.
